// File: rtl/dw01_add_seq_8.sv
// dw01_add_seq_8 -- digit-serial adder: {CO, SUM} = A + B + CI.
//
// A single DIGIT-bit adder slice and a carry register process the operands,
// least significant digit first, over N = WIDTH/DIGIT RUN cycles. A
// START/BUSY/DONE handshake sequences each operation.
//
// Handshake: START is accepted on any rising CLK edge where the FSM is in
// IDLE or FIN. A, B and CI are sampled only on that edge. START seen in RUN
// is ignored. BUSY is high for exactly the N cycles of RUN. DONE is high for
// the single FIN cycle that follows. SUM and CO change only on the edge that
// enters FIN, and they hold that value until the next such edge or a reset.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset, priority over START
//   START      in   operation request
//   A, B       in   WIDTH-bit unsigned operands
//   CI         in   carry-in
//   BUSY       out  operation in progress (RUN)
//   DONE       out  one-cycle result strobe (FIN)
//   SUM        out  registered (A+B+CI) mod 2^WIDTH
//   CO         out  registered carry-out
//   state_dbg  out  current FSM state (0=IDLE, 1=RUN, 2=FIN)
//
// DIGIT must divide WIDTH exactly.

module dw01_add_seq_8 #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] psum_next;

  // Shared adder slice: low digit of each operand plus the running carry.
  assign digit_sum = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};

  // The new digit enters at the top of the partial sum. After N shifts the
  // first digit has reached bit 0, so the register holds the full result.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign psum_next = digit_sum[DIGIT-1:0];
    end else begin : g_multi
      assign psum_next = {digit_sum[DIGIT-1:0], psum[WIDTH-1:DIGIT]};
    end
  endgenerate

  // BUSY and DONE decode straight from the state register, so they are
  // glitch-free and can never be high together.
  assign BUSY      = (state == RUN);
  assign DONE      = (state == FIN);
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      CO    <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            a_r   <= A;
            b_r   <= B;
            carry <= CI;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          carry <= digit_sum[DIGIT];
          psum  <= psum_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            SUM   <= psum_next;
            CO    <= digit_sum[DIGIT];
            state <= FIN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
